// File: rtl/wb_bus_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect.
//   - Bus field widths (address, data, byte select).
//   - clog2 helper for sizing index signals.
//   - Bus state encoding used by the arbiter and the top level.
package wb_bus_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Ceiling log2. Returns 0 for a value of 1, so callers that need
  // a signal of at least one bit must clamp the result.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin bus arbiter with a hold-for-whole-cycle grant.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : per-master request (Wishbone cyc)
//   state      : IDLE or BUSY (registered)
//   grant_idx  : index of the granted master (valid while BUSY)
//   grant_oh   : one-hot grant, all zero while IDLE
// The search starts at ptr_q and wraps. A release always passes through
// one IDLE cycle, after which ptr_q points just past the last owner.
module wb_rr_arbiter
  import wb_bus_pkg::*;
#(
  parameter int NM = 2,
  localparam int IW = (NM > 1) ? clog2(NM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NM-1:0] req,
  output bus_state_e    state,
  output logic [IW-1:0] grant_idx,
  output logic [NM-1:0] grant_oh
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr_next;
  int            cand;

  // Walk the requesters from ptr_q upward (wrapping). Iterating the offset
  // downward lets the smallest offset overwrite the others.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pick_idx = ptr_q;
    cand     = 0;
    for (int k = NM - 1; k >= 0; k--) begin
      cand = int'(ptr_q) + k;
      if (cand >= NM) cand = cand - NM;
      if (req[cand]) pick_idx = IW'(cand);
    end
  end

  assign ptr_next = (grant_idx == IW'(NM - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      grant_oh  <= '0;
      ptr_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= BUSY;
            grant_idx <= pick_idx;
            grant_oh  <= NM'(1) << pick_idx;
          end
        end
        BUSY: begin
          if (!req[grant_idx]) begin
            state    <= IDLE;
            grant_oh <= '0;
            ptr_q    <= ptr_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_conbus_rr.sv
// Parametrised Wishbone shared-bus interconnect (NM masters, NS slaves).
//   sys_clk, sys_rst        : clock, asynchronous active-high reset
//   m_*_i / m_*_o           : master-side ports, packed per master
//   m_dat_o                 : read data broadcast to all masters
//   s_adr_o/dat_o/sel_o/we_o: shared slave request fields
//   s_cyc_o, s_stb_o        : per-slave cycle and strobe
//   s_dat_i, s_ack_i        : per-slave read data and acknowledge
// Round-robin arbitration holds the grant for the whole bus cycle. The
// granted address is decoded against S_ADDR (lowest matching entry wins);
// an unmatched address is terminated with a repeating registered error.
// A watchdog ends stalled slave cycles with a one-cycle error after
// TIMEOUT cycles of strobe without ack (TIMEOUT = 0 disables it).
module wb_conbus_rr
  import wb_bus_pkg::*;
#(
  parameter int                      NM       = 2,
  parameter int                      NS       = 6,
  parameter int                      S_ADDR_W = 3,
  parameter logic [NS*S_ADDR_W-1:0]  S_ADDR   = {3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000},
  parameter int                      TIMEOUT  = 255,
  parameter int                      TO_W     = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NM*WB_ADR_W-1:0] m_adr_i,
  input  logic [NM*WB_DAT_W-1:0] m_dat_i,
  output logic [WB_DAT_W-1:0]    m_dat_o,
  input  logic [NM*WB_SEL_W-1:0] m_sel_i,
  input  logic [NM-1:0]          m_we_i,
  input  logic [NM-1:0]          m_cyc_i,
  input  logic [NM-1:0]          m_stb_i,
  output logic [NM-1:0]          m_ack_o,
  output logic [NM-1:0]          m_err_o,
  output logic [WB_ADR_W-1:0]    s_adr_o,
  output logic [WB_DAT_W-1:0]    s_dat_o,
  output logic [WB_SEL_W-1:0]    s_sel_o,
  output logic                   s_we_o,
  output logic [NS-1:0]          s_cyc_o,
  output logic [NS-1:0]          s_stb_o,
  input  logic [NS*WB_DAT_W-1:0] s_dat_i,
  input  logic [NS-1:0]          s_ack_i
);

  localparam int IW = (NM > 1) ? clog2(NM) : 1;

  bus_state_e    state;
  logic [IW-1:0] grant_idx;
  logic [NM-1:0] grant_oh;
  logic          busy;

  wb_rr_arbiter #(.NM(NM)) u_arb (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .req       (m_cyc_i),
    .state     (state),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh)
  );

  assign busy = (state == BUSY);

  // Granted master's request; all zero while no master owns the bus.
  logic [WB_ADR_W-1:0] g_adr;
  logic [WB_DAT_W-1:0] g_dat;
  logic [WB_SEL_W-1:0] g_sel;
  logic                g_we;
  logic                g_cyc;
  logic                g_stb;

  always_comb begin
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    if (busy) begin
      g_adr = m_adr_i[grant_idx*WB_ADR_W +: WB_ADR_W];
      g_dat = m_dat_i[grant_idx*WB_DAT_W +: WB_DAT_W];
      g_sel = m_sel_i[grant_idx*WB_SEL_W +: WB_SEL_W];
      g_we  = m_we_i[grant_idx];
      g_cyc = m_cyc_i[grant_idx];
      g_stb = m_stb_i[grant_idx];
    end
  end

  // Address decode. Gated by busy: the idle address of zero would
  // otherwise select whichever slave owns the all-zero region.
  logic [NS-1:0] sel;
  logic          hit;

  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (busy && (g_adr[WB_ADR_W-1 -: S_ADDR_W] == S_ADDR[i*S_ADDR_W +: S_ADDR_W])) begin
        sel    = '0;
        sel[i] = 1'b1;
        hit    = 1'b1;
      end
    end
  end

  // Selected slave's response; acks from other slaves never reach a master.
  logic [WB_DAT_W-1:0] rd_dat;
  logic                ack_sel;

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel[i]) rd_dat = s_dat_i[i*WB_DAT_W +: WB_DAT_W];
    end
  end

  assign ack_sel = |(s_ack_i & sel);

  // Watchdog and unmapped-address error state.
  logic [TO_W-1:0] wd_cnt;
  logic            err_q;
  logic            timeout;
  logic            stb_pend;

  assign stb_pend = g_cyc & g_stb;
  assign timeout  = (TIMEOUT != 0) && stb_pend && hit && (wd_cnt == TO_W'(TIMEOUT));

  // NOTE: only control state is reset; the bus outputs are pure functions
  // of the reset registers and so fall to zero with them.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      // Unmapped strobe: error on the next cycle, then one quiet cycle,
      // repeating for as long as the strobe is held.
      err_q <= stb_pend & ~hit & ~err_q;

      if (!busy || ack_sel || err_q || timeout) begin
        wd_cnt <= '0;
      end else if ((TIMEOUT != 0) && stb_pend && hit) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  // Slave side. The strobe is withdrawn in the timeout cycle so the slave
  // does not complete a transfer the master is told has failed.
  assign s_adr_o = g_adr;
  assign s_dat_o = g_dat;
  assign s_sel_o = g_sel;
  assign s_we_o  = g_we;
  assign s_cyc_o = sel & {NS{g_cyc}};
  assign s_stb_o = sel & {NS{g_stb & ~timeout}};

  // Master side. grant_oh is zero while idle, so non-owners see nothing,
  // and error always masks a coincident ack.
  assign m_dat_o = rd_dat;
  assign m_ack_o = grant_oh & {NM{ack_sel & ~timeout & ~err_q}};
  assign m_err_o = grant_oh & {NM{err_q | timeout}};

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Directed self-checking bench for wb_conbus_rr (NM=2, NS=6, TIMEOUT=16).
// Inputs are driven just after the falling edge and outputs are sampled
// 1 ns later, well away from the rising edge the design samples on.
// Decode table: s0=000 s1=010 s2=011 s3=100 s4=101 s5=110 on adr[31:29].
module tb_wb_conbus_rr;

  localparam int NM = 2;
  localparam int NS = 6;

  logic              sys_clk;
  logic              sys_rst;
  logic [NM*32-1:0]  m_adr_i;
  logic [NM*32-1:0]  m_dat_i;
  logic [31:0]       m_dat_o;
  logic [NM*4-1:0]   m_sel_i;
  logic [NM-1:0]     m_we_i;
  logic [NM-1:0]     m_cyc_i;
  logic [NM-1:0]     m_stb_i;
  logic [NM-1:0]     m_ack_o;
  logic [NM-1:0]     m_err_o;
  logic [31:0]       s_adr_o;
  logic [31:0]       s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic [NS-1:0]     s_cyc_o;
  logic [NS-1:0]     s_stb_o;
  logic [NS*32-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i;

  int checks   = 0;
  int failures = 0;

  wb_conbus_rr #(
    .NM      (NM),
    .NS      (NS),
    .TIMEOUT (16),
    .TO_W    (8)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_sel_i (m_sel_i),
    .m_we_i  (m_we_i),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic nxt();
    @(negedge sys_clk);
  endtask

  task automatic master_req(input int m, input logic [31:0] adr);
    m_adr_i[m*32 +: 32] = adr;
    m_dat_i[m*32 +: 32] = 32'hC0DE_0000 | m;
    m_sel_i[m*4 +: 4]   = 4'hF;
    m_we_i[m]           = 1'b0;
    m_cyc_i[m]          = 1'b1;
    m_stb_i[m]          = 1'b1;
  endtask

  task automatic master_drop(input int m);
    m_cyc_i[m] = 1'b0;
    m_stb_i[m] = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
    m_cyc_i = '0; m_stb_i = '0; s_dat_i = '0; s_ack_i = '0;
    nxt(); nxt();
    sys_rst = 1'b0;
    #1;
    checks++;
    if (s_cyc_o !== 6'b0 || s_stb_o !== 6'b0) begin
      failures++; $display("FAIL reset_slave cyc=%b stb=%b expected 0", s_cyc_o, s_stb_o);
    end
    checks++;
    if (m_ack_o !== 2'b0 || m_err_o !== 2'b0) begin
      failures++; $display("FAIL reset_master ack=%b err=%b expected 0", m_ack_o, m_err_o);
    end
    checks++;
    if (s_adr_o !== 32'h0 || s_dat_o !== 32'h0 || m_dat_o !== 32'h0 || s_sel_o !== 4'h0 || s_we_o !== 1'b0) begin
      failures++; $display("FAIL reset_bus adr=%h dat=%h mdat=%h expected 0", s_adr_o, s_dat_o, m_dat_o);
    end
    checks++;
    if (dut.u_arb.ptr_q !== 1'b0) begin
      failures++; $display("FAIL reset_ptr got=%0d expected 0", dut.u_arb.ptr_q);
    end
  endtask

  task automatic test_round_robin();
    nxt();
    master_req(0, 32'h4000_0010);
    master_req(1, 32'h6000_0020);
    #1;
    checks++;
    if (s_cyc_o !== 6'b0) begin
      failures++; $display("FAIL rr_no_grant_yet s_cyc=%b expected 000000", s_cyc_o);
    end
    nxt(); #1;
    checks++;
    if (s_adr_o !== 32'h4000_0010 || s_cyc_o !== 6'b000010) begin
      failures++; $display("FAIL rr_first_m0 adr=%h cyc=%b expected 40000010/000010", s_adr_o, s_cyc_o);
    end
    nxt();
    master_drop(0);
    #1;
    nxt();
    master_req(0, 32'h4000_0010);
    #1;
    checks++;
    if (s_cyc_o !== 6'b0 || dut.u_arb.ptr_q !== 1'b1) begin
      failures++; $display("FAIL rr_idle_gap cyc=%b ptr=%0d expected 000000/1", s_cyc_o, dut.u_arb.ptr_q);
    end
    nxt(); #1;
    checks++;
    if (s_adr_o !== 32'h6000_0020 || s_cyc_o !== 6'b000100 || s_dat_o !== 32'hC0DE_0001) begin
      failures++; $display("FAIL rr_then_m1 adr=%h cyc=%b dat=%h expected 60000020/000100/c0de0001", s_adr_o, s_cyc_o, s_dat_o);
    end
    nxt();
    master_drop(1);
    nxt(); #1;
    checks++;
    if (dut.u_arb.ptr_q !== 1'b0) begin
      failures++; $display("FAIL rr_ptr_back got=%0d expected 0", dut.u_arb.ptr_q);
    end
    nxt(); #1;
    checks++;
    if (s_adr_o !== 32'h4000_0010) begin
      failures++; $display("FAIL rr_m0_again adr=%h expected 40000010", s_adr_o);
    end
    nxt();
    master_drop(0);
    nxt();
  endtask

  task automatic test_read();
    nxt();
    master_req(0, 32'h4000_0004);
    s_dat_i[0*32 +: 32] = 32'hDEAD_BEEF;
    s_dat_i[1*32 +: 32] = 32'h0000_00A5;
    s_ack_i[0] = 1'b1;
    #1;
    nxt(); #1;
    checks++;
    if (s_cyc_o !== 6'b000010 || s_stb_o !== 6'b000010) begin
      failures++; $display("FAIL read_decode cyc=%b stb=%b expected 000010", s_cyc_o, s_stb_o);
    end
    checks++;
    if (m_ack_o !== 2'b00) begin
      failures++; $display("FAIL read_stray_ack ack=%b expected 00", m_ack_o);
    end
    nxt(); #1;
    checks++;
    if (m_ack_o !== 2'b00) begin
      failures++; $display("FAIL read_wait ack=%b expected 00", m_ack_o);
    end
    nxt();
    s_ack_i[1] = 1'b1;
    #1;
    checks++;
    if (m_ack_o !== 2'b01 || m_dat_o !== 32'h0000_00A5 || m_err_o !== 2'b00) begin
      failures++; $display("FAIL read_ack ack=%b dat=%h err=%b expected 01/000000a5/00", m_ack_o, m_dat_o, m_err_o);
    end
    nxt();
    s_ack_i = '0;
    master_drop(0);
    #1;
    checks++;
    if (s_cyc_o !== 6'b0 || m_ack_o !== 2'b00) begin
      failures++; $display("FAIL read_release cyc=%b ack=%b expected 0", s_cyc_o, m_ack_o);
    end
    nxt(); #1;
    checks++;
    if (s_adr_o !== 32'h0 || m_dat_o !== 32'h0) begin
      failures++; $display("FAIL read_idle adr=%h dat=%h expected 0", s_adr_o, m_dat_o);
    end
  endtask

  task automatic test_unmapped();
    nxt();
    master_req(1, 32'hE000_0000);
    nxt(); #1;
    checks++;
    if (s_cyc_o !== 6'b0 || m_err_o !== 2'b00 || m_ack_o !== 2'b00) begin
      failures++; $display("FAIL unmap_stb_cycle cyc=%b err=%b ack=%b expected 0", s_cyc_o, m_err_o, m_ack_o);
    end
    nxt();
    s_ack_i = '1;
    #1;
    checks++;
    if (m_err_o !== 2'b10 || m_ack_o !== 2'b00) begin
      failures++; $display("FAIL unmap_err err=%b ack=%b expected 10/00", m_err_o, m_ack_o);
    end
    nxt();
    s_ack_i = '0;
    #1;
    checks++;
    if (m_err_o !== 2'b00) begin
      failures++; $display("FAIL unmap_gap err=%b expected 00", m_err_o);
    end
    nxt(); #1;
    checks++;
    if (m_err_o !== 2'b10) begin
      failures++; $display("FAIL unmap_repeat err=%b expected 10", m_err_o);
    end
    nxt();
    master_drop(1);
    #1;
    checks++;
    if (m_err_o !== 2'b00) begin
      failures++; $display("FAIL unmap_release err=%b expected 00", m_err_o);
    end
    nxt();
  endtask

  task automatic test_timeout();
    nxt();
    master_req(0, 32'h4000_0000);
    nxt(); #1;
    checks++;
    if (s_stb_o !== 6'b000010) begin
      failures++; $display("FAIL to_stb stb=%b expected 000010", s_stb_o);
    end
    for (int k = 1; k <= 33; k++) begin
      nxt(); #1;
      checks++;
      if (k == 16 || k == 33) begin
        if (m_err_o !== 2'b01 || s_stb_o !== 6'b0 || s_cyc_o !== 6'b000010) begin
          failures++; $display("FAIL to_fire k=%0d err=%b stb=%b cyc=%b expected 01/000000/000010", k, m_err_o, s_stb_o, s_cyc_o);
        end
      end else begin
        if (m_err_o !== 2'b00 || s_stb_o !== 6'b000010) begin
          failures++; $display("FAIL to_wait k=%0d err=%b stb=%b expected 00/000010", k, m_err_o, s_stb_o);
        end
      end
    end
    nxt();
    master_drop(0);
    nxt();
  endtask

  task automatic test_timeout_ack();
    nxt();
    master_req(0, 32'h4000_0000);
    nxt();
    for (int k = 1; k <= 16; k++) begin
      nxt();
      if (k == 16) s_ack_i[1] = 1'b1;
    end
    #1;
    checks++;
    if (m_err_o !== 2'b01 || m_ack_o !== 2'b00) begin
      failures++; $display("FAIL to_ack_race err=%b ack=%b expected 01/00", m_err_o, m_ack_o);
    end
    nxt();
    s_ack_i = '0;
    master_drop(0);
    nxt();
  endtask

  task automatic test_reset_midcycle();
    nxt();
    master_req(1, 32'h1000_0000);
    nxt(); #1;
    checks++;
    if (s_cyc_o !== 6'b000001) begin
      failures++; $display("FAIL rst_pre cyc=%b expected 000001", s_cyc_o);
    end
    nxt();
    s_ack_i[0] = 1'b1;
    sys_rst    = 1'b1;
    #1;
    checks++;
    if (s_cyc_o !== 6'b0 || m_ack_o !== 2'b00 || s_adr_o !== 32'h0) begin
      failures++; $display("FAIL rst_async cyc=%b ack=%b adr=%h expected 0", s_cyc_o, m_ack_o, s_adr_o);
    end
    master_req(0, 32'h4000_0008);
    nxt();
    s_ack_i = '0;
    sys_rst = 1'b0;
    #1;
    checks++;
    if (dut.u_arb.ptr_q !== 1'b0 || s_cyc_o !== 6'b0) begin
      failures++; $display("FAIL rst_ptr ptr=%0d cyc=%b expected 0/000000", dut.u_arb.ptr_q, s_cyc_o);
    end
    nxt(); #1;
    checks++;
    if (s_adr_o !== 32'h4000_0008) begin
      failures++; $display("FAIL rst_regrant adr=%h expected 40000008", s_adr_o);
    end
    nxt();
    master_drop(0);
    master_drop(1);
    nxt(); nxt();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read();
    test_unmapped();
    test_timeout();
    test_timeout_ack();
    test_reset_midcycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
